alu_share_ctrl: RTL

- Sequencer that time-shares the single 64-bit ALU between two requesters, for example the execute stage and an address/branch-compare helper.
- Accepts one operation at a time over valid/ready and drives the ALU operand and control inputs.
- Captures the ALU result and zero flag, then returns them tagged with the requester ID over a valid/ready response channel.
- Arbitration is round-robin.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_share_ctrl_rr_arb2.sv | 16 +
 rtl/alu_share_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share controller: widths, ALU control codes, FSM encoding.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W_DEF = 4;

  localparam logic [CTRL_W_DEF-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W_DEF-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W_DEF-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W_DEF-1:0] CTRL_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for the four control codes the ALU implements.
  function automatic logic ctrl_legal(input logic [CTRL_W_DEF-1:0] code);
    return (code == CTRL_AND) || (code == CTRL_OR) ||
           (code == CTRL_ADD) || (code == CTRL_SUB);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin grant; prio selects the winner when both are valid.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic gnt0,
  output logic gnt1
);

  // Grant the sole requester, or the favoured one on a tie.
  always_comb begin
    gnt0 = valid0 && (!valid1 || !prio);
    gnt1 = valid1 && (!valid0 ||  prio);
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters with round-robin
// arbitration and a tagged valid/ready response channel.
// Optional macro ALU_OPCHK_EN: reject illegal control codes with rsp_err.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  state_t            state;
  logic              prio;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [CTRL_W-1:0] sel_ctrl;
  logic              op_legal;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .prio   (prio),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Operand mux for the granted requester and legality of its control code.
  always_comb begin
    sel_a    = gnt1 ? req1_a    : req0_a;
    sel_b    = gnt1 ? req1_b    : req0_b;
    sel_ctrl = gnt1 ? req1_ctrl : req0_ctrl;
`ifdef ALU_OPCHK_EN
    op_legal = ctrl_legal(CTRL_W_DEF'(sel_ctrl));
`else
    op_legal = 1'b1;
`endif
  end

  // Accept handshake completes in the same IDLE cycle as the grant.
  always_comb begin
    req0_ready = !rst && (state == ST_IDLE) && gnt0;
    req1_ready = !rst && (state == ST_IDLE) && gnt1;
  end

  // Sequencer: IDLE grants and latches operands, EXEC captures the ALU, RESP waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
`ifdef ALU_OPCHK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            rsp_id <= gnt1;
            if (op_legal) begin
              alu_a    <= sel_a;
              alu_b    <= sel_b;
              alu_ctrl <= sel_ctrl;
              state    <= ST_EXEC;
            end else begin
              // Illegal code: respond immediately, ALU operands untouched.
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end
`ifdef ALU_OPCHK_EN
            rsp_err <= !op_legal;
`endif
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= !rsp_id;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef ALU_OPCHK_EN
  assign rsp_err = 1'b0;
`endif

endmodule
